serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor, a = minuend, b = subtrahend.

---
 rtl/serial_subtractor_if.sv | 46 ++++
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Handshake and operand/result bundle for serial_subtractor.
//                master drives start/a/b and observes busy/done/diff/borrow_out;
//                slave is the subtractor side.
//  Ports       : start      - request, accepted in IDLE or DONE
//                a, b       - minuend / subtrahend, captured on accept
//                busy       - high while an operation is running
//                done       - one-cycle pulse when a result is published
//                diff       - a-b mod 2^WIDTH, held until next result
//                borrow_out - final borrow (a < b unsigned), held with diff
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  borrow_out
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output borrow_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor (diff = a - b). One bit pair
//                is processed per clock, LSB first, through two cascaded
//                half-subtractor cells with the borrow held in a flip-flop.
//                A result takes WIDTH cycles in RUN plus one DONE cycle.
//  Ports       : clk   - clock, rising-edge
//                reset - asynchronous, active-high
//                bus   - serial_subtractor_if.slave
//                        (start, a, b, busy, done, diff, borrow_out)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  serial_subtractor_if.slave    bus
);

  localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_sa;      // minuend shift register
  logic [WIDTH-1:0]   r_sb;      // subtrahend shift register
  logic [WIDTH-1:0]   r_acc;     // partial result, filled from the MSB side
  logic               r_bw;      // borrow carried between bit positions
  logic [c_CNT_W-1:0] r_cnt;     // index of the bit being processed
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;

  logic               w_accept;
  logic               w_last;

  // Half-subtractor cells
  logic               w_hs1_d;
  logic               w_hs1_b;
  logic               w_hs2_d;
  logic               w_hs2_b;
  logic               w_bw_nxt;

  // --------------------------------------------------------------------------
  // Bit-slice: first cell subtracts sb from sa, second subtracts the incoming
  // borrow from that partial difference. Either cell borrowing makes the
  // outgoing borrow (they can never both borrow at once).
  // --------------------------------------------------------------------------
  assign w_hs1_d  = r_sa[0] ^ r_sb[0];
  assign w_hs1_b  = ~r_sa[0] & r_sb[0];
  assign w_hs2_d  = w_hs1_d ^ r_bw;
  assign w_hs2_b  = ~w_hs1_d & r_bw;
  assign w_bw_nxt = w_hs1_b | w_hs2_b;

  // A request is honoured only when no operation is in flight; DONE accepts
  // too, which gives back-to-back operation with one idle-free cycle.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_cnt == c_LAST);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, serial shift and result publication
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_acc        <= '0;
      r_bw         <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= bus.a;
      r_sb  <= bus.b;
      r_acc <= '0;
      r_bw  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      // After WIDTH shifts the first (LSB) difference bit lands at bit 0.
      r_acc <= {w_hs2_d, r_acc[WIDTH-1:1]};
      r_bw  <= w_bw_nxt;
      r_cnt <= r_cnt + c_ONE;
      if (w_last) begin
        r_diff       <= {w_hs2_d, r_acc[WIDTH-1:1]};
        r_borrow_out <= w_bw_nxt;
      end
    end
  end

  // Status flags decode directly from state so an asynchronous reset clears
  // them immediately.
  assign bus.busy       = (r_state == ST_RUN);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor. Expected results
//                come from plain modular arithmetic on the applied operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cyc;

  // Model of the published result (last completed operation).
  logic [W-1:0] m_diff;
  logic         m_bo;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction modulo 2^W, borrow when a < b.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    m_diff = W'(int'(ma) - int'(mb) + (1 << W));
    m_bo   = (ma < mb);
  endtask

  // Called at the negedge of RUN cycle 1; checks WIDTH RUN cycles and
  // returns at the negedge of the DONE cycle.
  task automatic run_phase(input bit disturb);
    for (int i = 0; i < W; i++) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_run", 32'(bus.done), 32'd0);
      check("diff_hold", 32'(bus.diff), 32'(m_diff));
      check("bo_hold", 32'(bus.borrow_out), 32'(m_bo));
      if (disturb) begin
        bus.start = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    model(ta, tb_v);
    check("done", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd0);
    check("diff", 32'(bus.diff), 32'(m_diff));
    check("borrow_out", 32'(bus.borrow_out), 32'(m_bo));
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit disturb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    @(negedge clk);
    bus.start = 1'b0;
    run_phase(disturb);
    bus.start = 1'b0;
    check_done(ta, tb_v);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_diff", 32'(bus.diff), 32'(m_diff));
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    int           t_done1;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    m_diff    = '0;
    m_bo      = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bo", 32'(bus.borrow_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed operands, including the boundary cases
    do_op(8'd5,   8'd3,   1'b0);
    check("ex_5_3", 32'(bus.diff), 32'h02);
    do_op(8'd3,   8'd5,   1'b0);
    check("ex_3_5", 32'(bus.diff), 32'hFE);
    do_op(8'd0,   8'd1,   1'b0);
    check("ex_0_1", 32'(bus.diff), 32'hFF);
    do_op(8'hFF,  8'hFF,  1'b0);
    do_op(8'h80,  8'h7F,  1'b0);
    check("ex_80_7f", 32'(bus.diff), 32'h01);

    // Start and operands disturbed during RUN must not matter
    do_op(8'hA5, 8'h3C, 1'b1);

    // Back-to-back with start held high through DONE
    a1 = W'($urandom); b1 = W'($urandom);
    a2 = W'($urandom); b2 = W'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a1; bus.b = b1;
    @(negedge clk);
    bus.a = a2; bus.b = b2;
    run_phase(1'b0);
    check_done(a1, b1);
    t_done1 = cyc;
    @(negedge clk);
    run_phase(1'b0);
    check_done(a2, b2);
    check("b2b_spacing", 32'(cyc - t_done1), 32'd9);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(bus.done | bus.busy), 32'd0);

    // Make sure the published result is non-zero before the reset test
    do_op(8'd3, 8'd5, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_diff", 32'(bus.diff), 32'd0);
    check("mrst_bo", 32'(bus.borrow_out), 32'd0);
    m_diff = '0;
    m_bo   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("mrst_nodone", 32'(bus.done | bus.busy), 32'd0);
    end
    do_op(8'h10, 8'h20, 1'b0);

    // Randomised operations
    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
